// File: rtl/sum_load_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : sum_load_ctrl                                                |
// | Purpose : streams n words into the Sum SRAM, then runs Sum and         |
// |           captures its return value                                    |
// | Revision: 1.0 - initial release                                        |
// +------------------------------------------------------------------------+
module sum_load_ctrl #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int DEPTH   = 1024,
  parameter int TIMEOUT = 4096
) (
  input  logic              ap_clk,
  input  logic              ap_rst_n,
  input  logic              cmd_start,
  input  logic [31:0]       cfg_n,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic              mem_sel,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_d,
  output logic              mem_ce,
  output logic              mem_we,
  output logic              sum_start,
  output logic [31:0]       sum_n,
  input  logic              sum_done,
  input  logic [31:0]       sum_return,
  output logic              busy,
  output logic [31:0]       result,
  output logic              result_valid,
  output logic              err
);

  localparam logic [1:0] c_st_idle  = 2'd0;
  localparam logic [1:0] c_st_load  = 2'd1;
  localparam logic [1:0] c_st_drain = 2'd2;
  localparam logic [1:0] c_st_run   = 2'd3;

  localparam int                c_tmo_w    = $clog2(TIMEOUT + 1);
  localparam logic [c_tmo_w-1:0] c_tmo_last = c_tmo_w'(TIMEOUT - 1);
  localparam logic [c_tmo_w-1:0] c_tmo_one  = c_tmo_w'(1);
  localparam logic [31:0]        c_depth    = 32'(DEPTH);

  logic [1:0]         r_state;
  logic [1:0]         w_state_next;
  logic [31:0]        r_n;
  logic [31:0]        r_cnt;
  logic [c_tmo_w-1:0] r_tmo;
  logic               r_mem_we;
  logic [ADDR_W-1:0]  r_mem_addr;
  logic [DATA_W-1:0]  r_mem_d;
  logic [31:0]        r_result;
  logic               r_result_valid;
  logic               r_err;

  logic w_hs;
  logic w_cmd_load;
  logic w_last_beat;
  logic w_tmo_hit;

  assign w_hs        = s_valid & s_ready;
  assign w_cmd_load  = cmd_start & (cfg_n != 32'd0) & (cfg_n <= c_depth);
  assign w_last_beat = w_hs & (r_cnt == (r_n - 32'd1));
  assign w_tmo_hit   = (r_tmo == c_tmo_last);

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_state <= c_st_idle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      c_st_idle:  if (w_cmd_load) w_state_next = c_st_load;
      c_st_load:  if (w_last_beat) w_state_next = c_st_drain;
      c_st_drain: w_state_next = c_st_run;
      c_st_run:   if (sum_done || w_tmo_hit) w_state_next = c_st_idle;
      default:    w_state_next = c_st_idle;
    endcase
  end

  // mem_sel and sum_start both follow the state, so they swap on one edge
  always_comb begin
    s_ready   = 1'b0;
    mem_sel   = 1'b0;
    sum_start = 1'b0;
    sum_n     = 32'd0;
    busy      = (r_state != c_st_idle);
    case (r_state)
      c_st_load: begin
        s_ready = (r_cnt < r_n);
        mem_sel = 1'b1;
      end
      c_st_drain: mem_sel = 1'b1;
      c_st_run: begin
        sum_start = 1'b1;
        sum_n     = r_n;
      end
      default: ;
    endcase
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_n            <= '0;
      r_cnt          <= '0;
      r_tmo          <= '0;
      r_mem_we       <= 1'b0;
      r_mem_addr     <= '0;
      r_mem_d        <= '0;
      r_result       <= '0;
      r_result_valid <= 1'b0;
      r_err          <= 1'b0;
    end else begin
      r_mem_we <= w_hs;
      if (w_hs) begin
        r_mem_addr <= ADDR_W'(r_cnt);
        r_mem_d    <= s_data;
        r_cnt      <= r_cnt + 32'd1;
      end
      r_tmo <= (r_state == c_st_run) ? r_tmo + c_tmo_one : '0;
      case (r_state)
        c_st_idle: begin
          if (cmd_start) begin
            if (cfg_n == 32'd0) begin
              r_result       <= '0;
              r_result_valid <= 1'b1;
              r_err          <= 1'b0;
            end else if (cfg_n > c_depth) begin
              r_err          <= 1'b1;
              r_result_valid <= 1'b0;
            end else begin
              r_n            <= cfg_n;
              r_cnt          <= '0;
              r_err          <= 1'b0;
              r_result_valid <= 1'b0;
            end
          end
        end
        // completion takes priority over a simultaneous timeout
        c_st_run: begin
          if (sum_done) begin
            r_result       <= sum_return;
            r_result_valid <= 1'b1;
          end else if (w_tmo_hit) begin
            r_err <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign mem_ce       = r_mem_we;
  assign mem_we       = r_mem_we;
  assign mem_address  = r_mem_addr;
  assign mem_d        = r_mem_d;
  assign result       = r_result;
  assign result_valid = r_result_valid;
  assign err          = r_err;

endmodule
`default_nettype wire

// File: tb/tb_sum_load_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : tb_sum_load_ctrl                                             |
// | Purpose : randomized bench for sum_load_ctrl with a Sum/SRAM model     |
// | Revision: 1.0 - initial release                                        |
// +------------------------------------------------------------------------+
module tb_sum_load_ctrl;

  localparam int DEPTH   = 16;
  localparam int TIMEOUT = 40;

  logic        ap_clk = 1'b0;
  logic        ap_rst_n = 1'b0;
  logic        cmd_start = 1'b0;
  logic [31:0] cfg_n = '0;
  logic [31:0] s_data = '0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic        mem_sel;
  logic [31:0] mem_address;
  logic [31:0] mem_d;
  logic        mem_ce;
  logic        mem_we;
  logic        sum_start;
  logic [31:0] sum_n;
  logic        sum_done = 1'b0;
  logic [31:0] sum_return = '0;
  logic        busy;
  logic [31:0] result;
  logic        result_valid;
  logic        err;

  sum_load_ctrl #(.DATA_W(32), .ADDR_W(32), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .cmd_start(cmd_start), .cfg_n(cfg_n),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready), .mem_sel(mem_sel),
    .mem_address(mem_address), .mem_d(mem_d), .mem_ce(mem_ce), .mem_we(mem_we),
    .sum_start(sum_start), .sum_n(sum_n), .sum_done(sum_done), .sum_return(sum_return),
    .busy(busy), .result(result), .result_valid(result_valid), .err(err)
  );

  always #5 ap_clk = ~ap_clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // transaction-level model state
  logic [31:0] exp_addr_q[$];
  logic [31:0] exp_data_q[$];
  logic [31:0] sram[DEPTH];
  logic [31:0] exp_sum, last_res;
  int  accepted, writes, first_wr, last_wr, last_hs, start_rise, run_cycles;
  int  n_cur, sum_lat, vmode;
  bit  sum_hang, seq_data, prev_start, done_seen;
  bit  pat_q[$];

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic check_rst_outputs();
    check_eq("rst_ctl", {56'd0, s_ready, mem_sel, mem_ce, mem_we, sum_start, busy, result_valid, err}, 64'd0);
    check_eq("rst_addr", {32'd0, mem_address}, 64'd0);
    check_eq("rst_data", {32'd0, mem_d}, 64'd0);
    check_eq("rst_sum_n", {32'd0, sum_n}, 64'd0);
    check_eq("rst_result", {32'd0, result}, 64'd0);
  endtask

  // one clock: advance, then observe outputs and update the stream and Sum models
  task automatic step();
    bit          hs;
    logic [31:0] d;
    logic [31:0] s;
    int          c0;
    hs = (s_valid === 1'b1) && (s_ready === 1'b1);
    d  = s_data;
    c0 = cyc;
    @(posedge ap_clk);
    #1;
    cyc++;
    if (hs) begin
      exp_addr_q.push_back(32'(accepted));
      exp_data_q.push_back(d);
      exp_sum = exp_sum + d;
      accepted++;
      last_hs = c0;
      s_data = seq_data ? 32'(accepted + 1) : $urandom;
    end
    if (mem_we === 1'b1) begin
      writes++;
      if (first_wr < 0) first_wr = cyc;
      last_wr = cyc;
      if (exp_addr_q.size() == 0) begin
        check_eq("unexpected_write", 64'd1, 64'd0);
      end else begin
        check_eq("wr_addr", {32'd0, mem_address}, {32'd0, exp_addr_q.pop_front()});
        check_eq("wr_data", {32'd0, mem_d}, {32'd0, exp_data_q.pop_front()});
        check_eq("wr_sel_ce", {62'd0, mem_sel, mem_ce}, 64'd3);
      end
      if (mem_address < 32'(DEPTH)) sram[mem_address] = mem_d;
    end
    if (s_ready === 1'b1 && accepted >= n_cur)
      check_eq("ready_after_n", {63'd0, s_ready}, 64'd0);
    if (sum_done) begin
      sum_done = 1'b0;
      done_seen = 1'b1;
      check_eq("done_valid", {63'd0, result_valid}, 64'd1);
      check_eq("done_result", {32'd0, result}, {32'd0, exp_sum});
      check_eq("done_err", {63'd0, err}, 64'd0);
      check_eq("done_idle", {62'd0, busy, sum_start}, 64'd0);
    end else if (sum_start === 1'b1) begin
      if (!prev_start) begin
        start_rise = cyc;
        check_eq("sum_n", {32'd0, sum_n}, n_cur);
      end
      run_cycles++;
      check_eq("run_no_write", {61'd0, mem_sel, mem_we, mem_ce}, 64'd0);
      if (!sum_hang && run_cycles == sum_lat) begin
        s = '0;
        for (int i = 0; i < DEPTH; i++) if (32'(i) < sum_n) s = s + sram[i];
        sum_return = s;
        sum_done = 1'b1;
      end
    end
    prev_start = (sum_start === 1'b1);
    case (vmode)
      0: s_valid = 1'b1;
      1: s_valid = 1'($urandom_range(0, 1));
      default: s_valid = (pat_q.size() > 0) ? pat_q.pop_front() : 1'b1;
    endcase
  endtask

  task automatic prep(input int n, input int vm, input bit seqd, input int lat, input bit hang);
    exp_addr_q.delete();
    exp_data_q.delete();
    accepted = 0; writes = 0; first_wr = -1; last_wr = -1; last_hs = -1;
    start_rise = -1; run_cycles = 0; exp_sum = '0; done_seen = 1'b0;
    n_cur = n; vmode = vm; seq_data = seqd; sum_lat = lat; sum_hang = hang;
    s_data = seqd ? 32'd1 : $urandom;
    s_valid = 1'b0;
  endtask

  task automatic run_cmd(input int n, input int vm, input bit seqd, input int lat,
                         input bit hang, input bit timing);
    int acc, guard;
    bit poked;
    prep(n, vm, seqd, lat, hang);
    cfg_n = 32'(n);
    cmd_start = 1'b1;
    acc = cyc;
    step();
    cmd_start = 1'b0;
    check_eq("busy_accept", {63'd0, busy}, 64'd1);
    guard = 0;
    poked = 1'b0;
    while (busy === 1'b1 && guard < TIMEOUT + DEPTH * 16 + 100) begin
      cmd_start = hang && !poked && run_cycles == 5;
      if (cmd_start) begin
        poked = 1'b1;
        cfg_n = 32'd0;
      end
      step();
      guard++;
    end
    cmd_start = 1'b0;
    check_eq("cmd_bound", {63'd0, busy}, 64'd0);
    check_eq("n_writes", writes, n);
    check_eq("wq_empty", exp_addr_q.size(), 0);
    if (hang) begin
      check_eq("tmo_err", {62'd0, err, result_valid}, 64'd2);
      check_eq("tmo_len", run_cycles, TIMEOUT);
      check_eq("tmo_start", {63'd0, sum_start}, 64'd0);
      check_eq("tmo_result", {32'd0, result}, {32'd0, last_res});
    end else begin
      check_eq("done_seen", {63'd0, done_seen}, 64'd1);
      check_eq("run_len", run_cycles, lat);
      last_res = exp_sum;
    end
    if (timing) begin
      check_eq("first_wr_lat", first_wr - acc, 2);
      check_eq("wr_span", last_wr - first_wr, n - 1);
      check_eq("start_lat", start_rise - last_hs, 2);
    end
    step();
    step();
    check_eq("hold_result", {31'd0, result, result_valid}, hang ? {31'd0, last_res, 1'b0} : {31'd0, last_res, 1'b1});
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) sram[i] = '0;
    last_res = '0;
    prep(0, 0, 1'b0, 1, 1'b0);
    repeat (3) step();
    check_rst_outputs();
    ap_rst_n = 1'b1;
    step();
    check_rst_outputs();

    // back-to-back 1..10, Sum answers after 12 cycles
    run_cmd(10, 0, 1'b1, 12, 1'b0, 1'b1);
    check_eq("t1_result", {32'd0, result}, 64'd55);

    // gappy stream
    pat_q = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    run_cmd(4, 2, 1'b0, 3, 1'b0, 1'b0);

    // n = 0 completes at once; a stray sum_done in IDLE is ignored
    prep(0, 0, 1'b0, 1, 1'b0);
    cfg_n = 32'd0;
    cmd_start = 1'b1;
    step();
    cmd_start = 1'b0;
    check_eq("zero_status", {60'd0, result_valid, err, busy, s_ready}, 64'h8);
    check_eq("zero_result", {32'd0, result}, 64'd0);
    sum_return = 32'd99;
    sum_done = 1'b1;
    step();
    repeat (3) step();
    check_eq("zero_no_write", writes, 0);
    check_eq("zero_no_start", start_rise, -1);
    last_res = '0;

    // n = DEPTH + 1 is rejected
    cfg_n = 32'(DEPTH + 1);
    cmd_start = 1'b1;
    step();
    cmd_start = 1'b0;
    check_eq("big_status", {61'd0, err, result_valid, busy}, 64'h4);
    repeat (3) step();
    check_eq("big_busy", {63'd0, busy}, 64'd0);

    // largest legal n at full rate; Sum done on the final RUN cycle
    run_cmd(DEPTH, 0, 1'b0, TIMEOUT, 1'b0, 1'b1);

    // Sum never answers; cmd_start during RUN is ignored
    run_cmd(3, 0, 1'b0, 1, 1'b1, 1'b0);

    for (int k = 0; k < 10; k++)
      run_cmd($urandom_range(1, DEPTH), $urandom_range(0, 1), 1'b0,
              $urandom_range(1, 10), 1'b0, 1'b0);

    // asynchronous reset after 5 of 10 beats
    prep(10, 0, 1'b0, 5, 1'b0);
    cfg_n = 32'd10;
    cmd_start = 1'b1;
    step();
    cmd_start = 1'b0;
    for (int g = 0; g < 50 && accepted < 5; g++) step();
    check_eq("mid_beats", accepted, 5);
    #2;
    ap_rst_n = 1'b0;
    #1;
    check_rst_outputs();
    step();
    step();
    check_rst_outputs();
    ap_rst_n = 1'b1;
    last_res = '0;
    run_cmd(2, 0, 1'b0, 3, 1'b0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
